// File: rtl/ahb_apb_bridge_gen.sv
// ahb_apb_bridge_gen: AHB-lite slave to APB3 master bridge with NUM_SLOTS PSEL lines.
// Adds PREADY wait states, PSLVERR-to-HRESP mapping and an error for slots outside NUM_SLOTS.
// Optional PREADY watchdog: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
// Every output is registered. A synchronous active-high SYSRST returns all outputs to idle values.
module ahb_apb_bridge_gen #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_SLOTS = 16,
    parameter int unsigned SLOT_LSB  = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 SYSCLK,
    input  logic                 SYSRST,
    input  logic                 HSEL,
    input  logic [ADDR_W-1:0]    HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [DATA_W-1:0]    HWDATA,
    input  logic                 HREADYIN,
    output logic                 HREADYOUT,
    output logic [DATA_W-1:0]    HRDATA,
    output logic                 HRESP,
    output logic [NUM_SLOTS-1:0] PSEL,
    output logic [ADDR_W-1:0]    PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [DATA_W-1:0]    PWDATA,
    input  logic [DATA_W-1:0]    PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    // The slot field is decoded over the full 32-slot range, so an address beyond
    // NUM_SLOTS raises an AHB error instead of aliasing onto a lower slot.
    localparam int unsigned SLOT_FW = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LATCH  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR1   = 3'd5;
    localparam logic [2:0] ST_ERR2   = 3'd6;

    logic [2:0]           state;
    logic [ADDR_W-1:0]    haddr_q;
    logic                 hwrite_q;
    logic [SLOT_FW-1:0]   slot_q;
    logic                 accept;
    logic                 slot_bad;
    logic [NUM_SLOTS-1:0] psel_dec;
    logic                 unused_htrans;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TMO_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned TMO_W   = (TMO_RAW < 8) ? 8 : ((TMO_RAW > 16) ? 16 : TMO_RAW);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT != 0);
`endif

    assign unused_htrans = HTRANS[0];

    // Transfer acceptance, slot range check and one-hot select decode.
    always_comb begin
        accept = 1'b0;
        if (state == ST_IDLE || state == ST_DONE || state == ST_ERR2) begin
            accept = HSEL & HREADYIN & HTRANS[1];
        end
        slot_bad = (32'(slot_q) >= NUM_SLOTS);
        psel_dec = NUM_SLOTS'(1) << slot_q;
    end

    // Bridge FSM with registered AHB and APB outputs.
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state     <= ST_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            slot_q    <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    HRESP <= 1'b0;
                    if (accept) begin
                        state     <= ST_LATCH;
                        haddr_q   <= HADDR;
                        hwrite_q  <= HWRITE;
                        slot_q    <= HADDR[SLOT_LSB +: SLOT_FW];
                        HREADYOUT <= 1'b0;
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (hwrite_q) begin
                        PWDATA <= HWDATA;
                    end
                    if (slot_bad) begin
                        state <= ST_ERR1;
                        HRESP <= 1'b1;
                    end else begin
                        state  <= ST_SETUP;
                        PSEL   <= psel_dec;
                        PADDR  <= haddr_q;
                        PWRITE <= hwrite_q;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            state <= ST_ERR1;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            HREADYOUT <= 1'b1;
                            if (!hwrite_q) begin
                                HRDATA <= PRDATA;
                            end
                        end
                    end else begin
`ifdef APB_TIMEOUT_EN
                        // Counter reaches TIMEOUT on this cycle: abort after exactly TIMEOUT waits.
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == TMO_LAST) begin
                            PSEL    <= '0;
                            PENABLE <= 1'b0;
                            state   <= ST_ERR1;
                            HRESP   <= 1'b1;
                        end
`endif
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= '0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_gen.sv
// tb_ahb_apb_bridge_gen: directed bench for ahb_apb_bridge_gen.
// dut uses 16 slots (TIMEOUT=8); dut4 uses 4 slots for the out-of-range slot case.
module tb_ahb_apb_bridge_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel, hsel4;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;

    logic        hreadyout, hresp, pwrite, penable;
    logic [31:0] hrdata, paddr, pwdata;
    logic [15:0] psel;

    logic        hreadyout4, hresp4, pwrite4, penable4;
    logic [31:0] hrdata4, paddr4, pwdata4;
    logic [3:0]  psel4;

    int checks = 0;
    int errors = 0;

    ahb_apb_bridge_gen #(.ADDR_W(32), .DATA_W(32), .NUM_SLOTS(16), .SLOT_LSB(8), .TIMEOUT(8)) dut (
        .SYSCLK(clk), .SYSRST(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
        .HWDATA(hwdata), .HREADYIN(hreadyout), .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp),
        .PSEL(psel), .PADDR(paddr), .PWRITE(pwrite), .PENABLE(penable), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    ahb_apb_bridge_gen #(.ADDR_W(32), .DATA_W(32), .NUM_SLOTS(4), .SLOT_LSB(8), .TIMEOUT(8)) dut4 (
        .SYSCLK(clk), .SYSRST(rst), .HSEL(hsel4), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
        .HWDATA(hwdata), .HREADYIN(hreadyout4), .HREADYOUT(hreadyout4), .HRDATA(hrdata4), .HRESP(hresp4),
        .PSEL(psel4), .PADDR(paddr4), .PWRITE(pwrite4), .PENABLE(penable4), .PWDATA(pwdata4),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        hsel   = 1'b0;
        hsel4  = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic addr_phase(input logic to4, input logic [31:0] a, input logic w);
        if (to4) hsel4 = 1'b1;
        else     hsel  = 1'b1;
        haddr  = a;
        hwrite = w;
        htrans = 2'b10;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_idle();
        tick();
        tick();
        checks++;
        if ({hreadyout, hresp, pwrite, penable} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/resp/pwr/pen=%b want 1000", {hreadyout, hresp, pwrite, penable});
        end
        checks++;
        if ({psel, hrdata, paddr, pwdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got psel=%h hrdata=%h paddr=%h pwdata=%h want 0", psel, hrdata, paddr, pwdata);
        end
        checks++;
        if ({hreadyout4, hresp4, psel4} !== 6'b10_0000) begin
            errors++;
            $display("FAIL reset_dut4 got %b want 100000", {hreadyout4, hresp4, psel4});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write;
        pready = 1'b1; pslverr = 1'b0;
        addr_phase(1'b0, 32'h0000_0104, 1'b1);
        tick();                                  // N+1
        bus_idle();
        hwdata = 32'hDEAD_BEEF;
        checks++;
        if (hreadyout !== 1'b0) begin errors++; $display("FAIL wr_latch_hready got %b want 0", hreadyout); end
        tick();                                  // N+2
        checks++;
        if ({psel, penable} !== {16'h0002, 1'b0}) begin
            errors++; $display("FAIL wr_setup got psel=%h pen=%b want 0002/0", psel, penable);
        end
        checks++;
        if ({paddr, pwrite, pwdata} !== {32'h0000_0104, 1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL wr_setup_bus got paddr=%h pwrite=%b pwdata=%h want 00000104/1/deadbeef", paddr, pwrite, pwdata);
        end
        tick();                                  // N+3
        checks++;
        if ({psel, penable, hreadyout} !== {16'h0002, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wr_access got psel=%h pen=%b rdy=%b want 0002/1/0", psel, penable, hreadyout);
        end
        tick();                                  // N+4
        checks++;
        if ({hreadyout, hresp, psel, penable} !== {2'b10, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL wr_done got rdy=%b resp=%b psel=%h pen=%b want 1/0/0000/0", hreadyout, hresp, psel, penable);
        end
        checks++;
        if (hrdata !== 32'h0) begin errors++; $display("FAIL wr_hrdata got %h want 00000000", hrdata); end
        tick();
    endtask

    task automatic test_wait_read;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h1234_5678;
        addr_phase(1'b0, 32'h0000_0300, 1'b0);
        tick();                                  // N+1
        bus_idle();
        tick();                                  // N+2
        checks++;
        if ({psel, penable, pwrite} !== {16'h0008, 2'b00}) begin
            errors++; $display("FAIL rd_setup got psel=%h pen=%b pwr=%b want 0008/0/0", psel, penable, pwrite);
        end
        for (int i = 3; i <= 6; i++) begin
            tick();                              // N+3..N+6
            checks++;
            if ({psel, penable, hreadyout} !== {16'h0008, 2'b10}) begin
                errors++; $display("FAIL rd_wait_n%0d got psel=%h pen=%b rdy=%b want 0008/1/0", i, psel, penable, hreadyout);
            end
            if (i == 6) pready = 1'b1;
        end
        tick();                                  // N+7
        checks++;
        if ({hreadyout, hresp, psel, penable} !== {2'b10, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL rd_done got rdy=%b resp=%b psel=%h pen=%b want 1/0/0000/0", hreadyout, hresp, psel, penable);
        end
        checks++;
        if (hrdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_hrdata got %h want 12345678", hrdata); end
        tick();
    endtask

    task automatic test_slverr;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
        addr_phase(1'b0, 32'h0000_0200, 1'b0);
        tick();                                  // N+1
        bus_idle();
        tick();                                  // N+2
        tick();                                  // N+3
        checks++;
        if ({psel, penable} !== {16'h0004, 1'b1}) begin
            errors++; $display("FAIL err_access got psel=%h pen=%b want 0004/1", psel, penable);
        end
        tick();                                  // N+4 ERR1
        checks++;
        if ({hreadyout, hresp, psel, penable} !== {2'b01, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL err_err1 got rdy=%b resp=%b psel=%h pen=%b want 0/1/0000/0", hreadyout, hresp, psel, penable);
        end
        tick();                                  // N+5 ERR2
        checks++;
        if ({hreadyout, hresp} !== 2'b11) begin errors++; $display("FAIL err_err2 got rdy/resp=%b want 11", {hreadyout, hresp}); end
        checks++;
        if (hrdata !== 32'h1234_5678) begin errors++; $display("FAIL err_hrdata got %h want 12345678", hrdata); end
        pslverr = 1'b0;
        tick();                                  // N+6 IDLE
        checks++;
        if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL err_idle got rdy/resp=%b want 10", {hreadyout, hresp}); end
    endtask

    task automatic test_bad_slot;
        pready = 1'b1; pslverr = 1'b0;
        addr_phase(1'b1, 32'h0000_0500, 1'b1);
        tick();                                  // N+1
        bus_idle();
        hwdata = 32'hCAFE_F00D;
        checks++;
        if ({hreadyout4, hresp4, psel4} !== 6'b00_0000) begin
            errors++; $display("FAIL slot_latch got %b want 000000", {hreadyout4, hresp4, psel4});
        end
        tick();                                  // N+2 ERR1
        checks++;
        if ({hreadyout4, hresp4, psel4, penable4} !== 7'b01_0000_0) begin
            errors++; $display("FAIL slot_err1 got %b want 0100000", {hreadyout4, hresp4, psel4, penable4});
        end
        tick();                                  // N+3 ERR2
        checks++;
        if ({hreadyout4, hresp4, psel4} !== 6'b11_0000) begin
            errors++; $display("FAIL slot_err2 got %b want 110000", {hreadyout4, hresp4, psel4});
        end
        tick();                                  // N+4 IDLE
        checks++;
        if ({hreadyout4, hresp4} !== 2'b10) begin errors++; $display("FAIL slot_idle got %b want 10", {hreadyout4, hresp4}); end
        checks++;
        if (psel !== 16'h0) begin errors++; $display("FAIL slot_other_dut got psel=%h want 0000", psel); end
        addr_phase(1'b1, 32'h0000_0300, 1'b0);   // highest valid slot on the 4-slot bridge
        tick();
        bus_idle();
        tick();
        checks++;
        if (psel4 !== 4'b1000) begin errors++; $display("FAIL slot3_setup got psel=%b want 1000", psel4); end
        tick();
        tick();
        checks++;
        if ({hreadyout4, hresp4} !== 2'b10) begin errors++; $display("FAIL slot3_done got %b want 10", {hreadyout4, hresp4}); end
        tick();
    endtask

    task automatic test_back_to_back;
        pready = 1'b1; pslverr = 1'b0;
        addr_phase(1'b0, 32'h0000_0104, 1'b1);
        tick();                                  // N+1
        bus_idle();
        hwdata = 32'h1111_1111;
        tick();                                  // N+2
        tick();                                  // N+3
        tick();                                  // N+4 DONE
        checks++;
        if ({hreadyout, psel} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL b2b_done got rdy=%b psel=%h want 1/0000", hreadyout, psel);
        end
        addr_phase(1'b0, 32'h0000_0200, 1'b1);
        tick();                                  // N+5 second LATCH
        bus_idle();
        hwdata = 32'h2222_2222;
        checks++;
        if ({hreadyout, psel} !== {1'b0, 16'h0000}) begin
            errors++; $display("FAIL b2b_latch got rdy=%b psel=%h want 0/0000", hreadyout, psel);
        end
        tick();                                  // N+6 SETUP
        checks++;
        if ({psel, pwdata, paddr} !== {16'h0004, 32'h2222_2222, 32'h0000_0200}) begin
            errors++; $display("FAIL b2b_setup got psel=%h pwdata=%h paddr=%h want 0004/22222222/00000200", psel, pwdata, paddr);
        end
        tick();                                  // N+7 ACCESS
        checks++;
        if ({psel, penable} !== {16'h0004, 1'b1}) begin
            errors++; $display("FAIL b2b_access got psel=%h pen=%b want 0004/1", psel, penable);
        end
        tick();                                  // N+8 DONE
        checks++;
        if ({hreadyout, hresp, hrdata} !== {2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL b2b_end got rdy=%b resp=%b hrdata=%h want 1/0/12345678", hreadyout, hresp, hrdata);
        end
        tick();
    endtask

    task automatic test_timeout;
        pready = 1'b0; pslverr = 1'b0;
        addr_phase(1'b0, 32'h0000_0104, 1'b0);
        tick();                                  // N+1
        bus_idle();
        tick();                                  // N+2
        tick();                                  // N+3 first ACCESS
`ifdef APB_TIMEOUT_EN
        repeat (7) tick();                       // N+10 eighth ACCESS
        checks++;
        if ({psel, penable, hreadyout} !== {16'h0002, 2'b10}) begin
            errors++; $display("FAIL tmo_last_access got psel=%h pen=%b rdy=%b want 0002/1/0", psel, penable, hreadyout);
        end
        tick();                                  // N+11 ERR1
        checks++;
        if ({hreadyout, hresp, psel, penable} !== {2'b01, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL tmo_err1 got rdy=%b resp=%b psel=%h pen=%b want 0/1/0000/0", hreadyout, hresp, psel, penable);
        end
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        tick();                                  // N+12 ERR2
        checks++;
        if ({hreadyout, hresp, psel} !== {2'b11, 16'h0000}) begin
            errors++; $display("FAIL tmo_err2 got rdy=%b resp=%b psel=%h want 1/1/0000", hreadyout, hresp, psel);
        end
        tick();
        checks++;
        if ({hreadyout, hresp, hrdata} !== {2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL tmo_late_pready got rdy=%b resp=%b hrdata=%h want 1/0/12345678", hreadyout, hresp, hrdata);
        end
`else
        repeat (20) tick();
        checks++;
        if ({psel, penable, hreadyout, hresp} !== {16'h0002, 3'b100}) begin
            errors++; $display("FAIL stuck_wait got psel=%h pen=%b rdy=%b resp=%b want 0002/1/0/0", psel, penable, hreadyout, hresp);
        end
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        tick();
        checks++;
        if ({hreadyout, hresp, hrdata} !== {2'b10, 32'h5555_AAAA}) begin
            errors++; $display("FAIL stuck_release got rdy=%b resp=%b hrdata=%h want 1/0/5555aaaa", hreadyout, hresp, hrdata);
        end
`endif
        tick();
    endtask

    task automatic test_reset_in_access;
        pready = 1'b0; pslverr = 1'b0;
        addr_phase(1'b0, 32'h0000_0104, 1'b1);
        tick();
        bus_idle();
        hwdata = 32'h7777_7777;
        tick();
        tick();                                  // ACCESS
        checks++;
        if ({psel, penable} !== {16'h0002, 1'b1}) begin
            errors++; $display("FAIL rst_pre got psel=%h pen=%b want 0002/1", psel, penable);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({psel, penable, hreadyout, hresp} !== {16'h0000, 3'b010}) begin
            errors++; $display("FAIL rst_access got psel=%h pen=%b rdy=%b resp=%b want 0000/0/1/0", psel, penable, hreadyout, hresp);
        end
        checks++;
        if ({hrdata, paddr, pwdata, pwrite} !== '0) begin
            errors++; $display("FAIL rst_access_data got hrdata=%h paddr=%h pwdata=%h pwr=%b want 0", hrdata, paddr, pwdata, pwrite);
        end
        rst = 1'b0;
        pready = 1'b1;
        tick();
        addr_phase(1'b0, 32'h0000_0104, 1'b1);
        tick();
        bus_idle();
        tick();
        checks++;
        if (psel !== 16'h0002) begin errors++; $display("FAIL rst_recover got psel=%h want 0002", psel); end
        tick();
        tick();
        checks++;
        if (hreadyout !== 1'b1) begin errors++; $display("FAIL rst_recover_done got rdy=%b want 1", hreadyout); end
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; hsel4 = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
        hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        test_reset();
        test_write();
        test_wait_read();
        test_slverr();
        test_bad_slot();
        test_back_to_back();
        test_timeout();
        test_reset_in_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
